// File: rtl/i2s_pkg.sv
// Shared I2S definitions: framing states, pattern modes, LFSR constants and
// default word/slot geometry used by both the transmitter and the receiver.
package i2s_pkg;

   localparam int unsigned DEF_WIDTH = 24;
   localparam int unsigned DEF_SLOT  = 32;

   localparam int unsigned LFSR_W    = 24;
   // x^24 + x^23 + x^22 + x^17 + 1 -> feedback taps on bits 23, 22, 21, 16
   localparam logic [LFSR_W-1:0] LFSR_SEED = 24'h000001;
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 24'hE10000;

   localparam logic [1:0] MODE_RAMP    = 2'd0;
   localparam logic [1:0] MODE_LFSR    = 2'd1;
   localparam logic [1:0] MODE_CONST   = 2'd2;
   localparam logic [1:0] MODE_SILENCE = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_e;

   // One Fibonacci step: shift toward the MSB, XOR of the taps enters at bit 0.
   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
      return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/i2s_pattern_gen.sv
// Test-pattern generator: ramp, LFSR, alternating constant and silence.
// On each advance strobe the mode is sampled, the stereo word pair for the
// new frame is latched, and only the generator of that mode steps forward.
module i2s_pattern_gen
   import i2s_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic             sck,
   input  logic             reset,
   input  logic             advance,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] left_word,
   output logic [WIDTH-1:0] right_word
);

   logic [WIDTH-1:0]  ramp_q, ramp_d;
   logic [LFSR_W-1:0] lfsr_q, lfsr_d;
   logic [WIDTH-1:0]  left_q, left_d;
   logic [WIDTH-1:0]  right_q, right_d;
   logic [WIDTH-1:0]  lfsr_top;
   logic [WIDTH-1:0]  lfsr_rev;
   logic [WIDTH-1:0]  alt_word;

   // Candidate words from the LFSR (top bits and their mirror) and the 1010.. constant
   always_comb begin
      lfsr_top = lfsr_q[LFSR_W-1 -: WIDTH];
      lfsr_rev = '0;
      alt_word = '0;
      for (int i = 0; i < WIDTH; i++) begin
         lfsr_rev[i] = lfsr_top[WIDTH-1-i];
         alt_word[i] = ((WIDTH - 1 - i) % 2) == 0;
      end
   end

   // Latch the frame's word pair and step the active generator on advance
   always_comb begin
      ramp_d  = ramp_q;
      lfsr_d  = lfsr_q;
      left_d  = left_q;
      right_d = right_q;
      if (advance) begin
         unique case (mode)
            MODE_RAMP: begin
               left_d  = ramp_q;
               right_d = ~ramp_q;
               ramp_d  = ramp_q + WIDTH'(1);
            end
            MODE_LFSR: begin
               left_d  = lfsr_top;
               right_d = lfsr_rev;
               lfsr_d  = lfsr_step(lfsr_q);
            end
            MODE_CONST: begin
               left_d  = alt_word;
               right_d = ~alt_word;
            end
            default: begin
               left_d  = '0;
               right_d = '0;
            end
         endcase
      end
   end

   // Generator state and latched words
   always_ff @(posedge sck) begin
      if (reset) begin
         ramp_q  <= '0;
         lfsr_q  <= LFSR_SEED;
         left_q  <= '0;
         right_q <= '0;
      end else begin
         ramp_q  <= ramp_d;
         lfsr_q  <= lfsr_d;
         left_q  <= left_d;
         right_q <= right_d;
      end
   end

   assign left_word  = left_q;
   assign right_word = right_q;

endmodule

// File: rtl/i2s_pattern_tx.sv
// I2S (Philips) master transmitter with built-in pattern source.
// Frames are LEFT (ws=0) then RIGHT (ws=1), SLOT sck each; data MSB first,
// one sck after each ws edge, zero padded. Optional build macro TX_PARITY_EN
// adds per-frame parity outputs; otherwise par_left/par_right are tied 0.
module i2s_pattern_tx
   import i2s_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned SLOT  = DEF_SLOT
) (
   input  logic       sck,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] mode,
   output logic       ws,
   output logic       sd,
   output logic       frame_strobe,
   output logic       par_left,
   output logic       par_right
);

   localparam int unsigned CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
   localparam logic [CNT_W-1:0] CNT_WIDTH = CNT_W'(WIDTH);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ws_q, ws_d;
   logic             sd_q, sd_d;
   logic             frame_strobe_q, frame_strobe_d;
   logic             frame_start_c;
   logic [WIDTH-1:0] left_word, right_word;
   logic [WIDTH-1:0] slot_word;
   logic [WIDTH-1:0] bit_mask;
   logic [CNT_W-1:0] bit_pos;

   i2s_pattern_gen #(
      .WIDTH (WIDTH)
   ) u_gen (
      .sck        (sck),
      .reset      (reset),
      .advance    (frame_start_c),
      .mode       (mode),
      .left_word  (left_word),
      .right_word (right_word)
   );

   // Framing FSM next state and registered-output values for the coming cycle
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      frame_start_c  = 1'b0;
      ws_d           = 1'b0;
      sd_d           = 1'b0;
      frame_strobe_d = 1'b0;
      slot_word      = left_word;
      bit_pos        = '0;
      bit_mask       = '0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d = LEFT;
               cnt_d   = '0;
            end
         end
         LEFT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = RIGHT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RIGHT: begin
            if (cnt_q == CNT_LAST) begin
               state_d = enable ? LEFT : IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      frame_start_c  = (state_d == LEFT) && (cnt_d == '0);
      frame_strobe_d = frame_start_c;
      ws_d           = (state_d == RIGHT);

      // k=0 is the I2S delay bit, k>WIDTH is padding; the word is already
      // latched by the time k=1 is produced, so the k=0 frame-start edge is safe.
      slot_word = (state_d == RIGHT) ? right_word : left_word;
      bit_pos   = CNT_WIDTH - cnt_d;
      bit_mask  = WIDTH'(1) << bit_pos;
      if ((state_d != IDLE) && (cnt_d != '0) && (cnt_d <= CNT_WIDTH)) begin
         sd_d = |(slot_word & bit_mask);
      end
   end

   // FSM and output registers
   always_ff @(posedge sck) begin
      if (reset) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         ws_q           <= 1'b0;
         sd_q           <= 1'b0;
         frame_strobe_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         ws_q           <= ws_d;
         sd_q           <= sd_d;
         frame_strobe_q <= frame_strobe_d;
      end
   end

   assign ws           = ws_q;
   assign sd           = sd_q;
   assign frame_strobe = frame_strobe_q;

`ifdef TX_PARITY_EN
   logic par_left_q, par_left_d;
   logic par_right_q, par_right_d;

   // Capture the frame's word parities during the last right-slot cycle
   always_comb begin
      par_left_d  = par_left_q;
      par_right_d = par_right_q;
      if ((state_d == RIGHT) && (cnt_d == CNT_LAST)) begin
         par_left_d  = ^left_word;
         par_right_d = ^right_word;
      end
   end

   // Parity registers
   always_ff @(posedge sck) begin
      if (reset) begin
         par_left_q  <= 1'b0;
         par_right_q <= 1'b0;
      end else begin
         par_left_q  <= par_left_d;
         par_right_q <= par_right_d;
      end
   end

   assign par_left  = par_left_q;
   assign par_right = par_right_q;
`else
   assign par_left  = 1'b0;
   assign par_right = 1'b0;
`endif

endmodule

// File: tb/tb_i2s_pattern_tx.sv
// Directed bench for i2s_pattern_tx (WIDTH=24, SLOT=32): deserialises each
// frame, checks framing, padding and pattern words against hand values.
module tb_i2s_pattern_tx;

   logic       sck;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic       ws;
   logic       sd;
   logic       frame_strobe;
   logic       par_left;
   logic       par_right;

   int checks = 0;
   int errors = 0;

   i2s_pattern_tx #(
      .WIDTH (24),
      .SLOT  (32)
   ) dut (
      .sck          (sck),
      .reset        (reset),
      .enable       (enable),
      .mode         (mode),
      .ws           (ws),
      .sd           (sd),
      .frame_strobe (frame_strobe),
      .par_left     (par_left),
      .par_right    (par_right)
   );

   initial sck = 1'b0;
   always #5 sck = ~sck;

   // Bound the whole run
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Observe one 64-cycle frame starting on the next negedge; optionally
   // change mode/enable after sample chg_at (63 = just before the next frame).
   task automatic run_frame(input string name, input int chg_at,
                            input logic [1:0] nmode, input logic nen,
                            input logic [23:0] exp_l, input logic [23:0] exp_r);
      logic [23:0] lw;
      logic [23:0] rw;
      int ws_err;
      int fs_err;
      int pad_err;
      int k;
      logic pl;
      logic pr;
      logic exp_pl;
      logic exp_pr;
      lw = '0; rw = '0; ws_err = 0; fs_err = 0; pad_err = 0; pl = 1'b0; pr = 1'b0;
      for (int j = 0; j < 64; j++) begin
         @(negedge sck);
         k = j % 32;
         if (ws !== (j >= 32)) ws_err++;
         if (frame_strobe !== (j == 0)) fs_err++;
         if (k >= 1 && k <= 24) begin
            if (j < 32) lw = {lw[22:0], sd};
            else        rw = {rw[22:0], sd};
         end else if (sd !== 1'b0) begin
            pad_err++;
         end
         if (j == 63) begin
            pl = par_left;
            pr = par_right;
         end
         if (j == chg_at) begin
            mode   = nmode;
            enable = nen;
         end
      end
`ifdef TX_PARITY_EN
      exp_pl = ^exp_l;
      exp_pr = ^exp_r;
`else
      exp_pl = 1'b0;
      exp_pr = 1'b0;
`endif
      check({name, "_left"},   32'(lw), 32'(exp_l));
      check({name, "_right"},  32'(rw), 32'(exp_r));
      check({name, "_ws"},     32'(ws_err), 32'd0);
      check({name, "_strobe"}, 32'(fs_err), 32'd0);
      check({name, "_pad"},    32'(pad_err), 32'd0);
      check({name, "_par"},    {30'd0, pl, pr}, {30'd0, exp_pl, exp_pr});
   endtask

   initial begin
      int idle_err;
      reset  = 1'b1;
      enable = 1'b0;
      mode   = 2'd0;
      repeat (3) @(posedge sck);
      @(negedge sck);
      check("reset_outs", {27'd0, ws, sd, frame_strobe, par_left, par_right}, 32'd0);

      // Start framing in ramp mode
      reset  = 1'b0;
      enable = 1'b1;
      run_frame("ramp0", -1, 2'd0, 1'b1, 24'h000000, 24'hFFFFFF);
      run_frame("ramp1", 10, 2'd2, 1'b1, 24'h000001, 24'hFFFFFE);
      run_frame("const", 63, 2'd1, 1'b1, 24'hAAAAAA, 24'h555555);
      run_frame("lfsr0", -1, 2'd1, 1'b1, 24'h000001, 24'h800000);
      run_frame("lfsr1", 63, 2'd0, 1'b1, 24'h000002, 24'h400000);
      run_frame("ramp2", 63, 2'd3, 1'b1, 24'h000002, 24'hFFFFFD);
      run_frame("silence", 63, 2'd0, 1'b1, 24'h000000, 24'h000000);
      run_frame("ramp3_drop", 10, 2'd0, 1'b0, 24'h000003, 24'hFFFFFC);

      // After the completed frame the block sits idle with quiet outputs
      idle_err = 0;
      for (int j = 0; j < 4; j++) begin
         @(negedge sck);
         if (ws !== 1'b0 || sd !== 1'b0 || frame_strobe !== 1'b0) idle_err++;
      end
      check("idle_quiet", 32'(idle_err), 32'd0);

      // Re-enable, then reset in the middle of the right slot
      enable = 1'b1;
      for (int j = 0; j < 37; j++) @(negedge sck);
      check("pre_reset_ws", {31'd0, ws}, 32'd1);
      reset = 1'b1;
      @(negedge sck);
      check("mid_reset_outs", {27'd0, ws, sd, frame_strobe, par_left, par_right}, 32'd0);

      // Ramp restarts from zero after reset
      reset = 1'b0;
      run_frame("post_reset", -1, 2'd0, 1'b1, 24'h000000, 24'hFFFFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2s_pattern_tx.md
Name: i2s_pattern_tx

Overview:
- I2S master-side transmitter and test-pattern source, clocked by the bit clock sck.
- Generates the ws and sd streams that feed the I2S receiver/re-serialiser stage directly downstream. Its ws and sd outputs connect to that stage's ws and sd inputs.
- Frames are stereo: left slot with ws low, then right slot with ws high. Data is MSB first and delayed one sck after each ws transition (Philips I2S).
- Sample words come from an internal generator selected by mode. The block gives on-chip bring-up without an external codec.

Parameters:
- WIDTH, 24, sample word width in bits. Legal range 8..24.
- SLOT, 32, sck cycles per channel slot. Must satisfy SLOT >= WIDTH+1.

Ports:
- sck  input  1  bit clock; all logic on posedge sck.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  start/continue framing.
- mode  input  2  pattern select, sampled at frame start.
- ws  output  1  word select: 0 = left slot, 1 = right slot.
- sd  output  1  serial data.
- frame_strobe  output  1  one-cycle pulse at each left-slot start.
- par_left  output  1  parity of the last completed left word (optional feature).
- par_right  output  1  parity of the last completed right word (optional feature).

Behaviour:
- Clocking and reset: one clock, sck. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - Outputs: ws=0, sd=0, frame_strobe=0, par_left=0, par_right=0.
  - Internal state: state=IDLE, bit counter cnt=0, ramp=0, lfsr=24'h000001.
- Reset asserted mid-frame aborts the frame on that edge. No partial slot completes.
- States:
  - IDLE: ws=0, sd=0. If enable=1, the next edge goes to LEFT with cnt=0.
  - LEFT: ws=0 for all SLOT cycles. When cnt=SLOT-1, go to RIGHT with cnt=0.
  - RIGHT: ws=1 for all SLOT cycles. When cnt=SLOT-1, go to LEFT with cnt=0 if enable=1, else to IDLE.
- enable deasserted mid-frame: the current frame always completes through the end of the right slot. Frame length is 2*SLOT sck cycles.
- Bit placement within a slot, for slot cycle cnt=k:
  - k=0: sd=0 (the one-bit I2S delay).
  - 1<=k<=WIDTH: sd=word[WIDTH-k], so MSB at k=1 and LSB at k=WIDTH.
  - k>WIDTH: sd=0 (padding).
- Frame start is LEFT with cnt=0:
  - mode is sampled.
  - left_word and right_word are latched for the whole frame.
  - frame_strobe=1 for exactly that cycle.
  - A mode change mid-frame takes effect at the next frame start.
- Patterns, latched at frame start:
  - mode 0 (ramp): left=ramp, right=~ramp. ramp increments by 1 after the latch and wraps mod 2^WIDTH.
  - mode 1 (lfsr): 24-bit Fibonacci LFSR, polynomial x^24+x^23+x^22+x^17+1. left=lfsr[23 -: WIDTH]; right=bit-reverse of left. The LFSR advances one step per frame.
  - mode 2 (constant): left=alternating 1010… starting at MSB=1, right=its complement.
  - mode 3 (silence): left=0, right=0.
  - ramp and lfsr advance only on frames in their own mode and hold otherwise.
- Back-to-back frames: the RIGHT slot's cnt=SLOT-1 cycle is followed directly by LEFT cnt=0, with no gap cycle.

Optional Feature:
- Macro: TX_PARITY_EN.
- Defined: par_left and par_right update at the end of the right slot (cnt=SLOT-1) to the XOR-reduction of that frame's left_word and right_word. They hold until the next frame end.
- Not defined: par_left and par_right are tied 0, and no parity logic is built.

Decomposition:
- Shared package i2s_pkg:
  - state enum: IDLE, LEFT, RIGHT.
  - mode constants: MODE_RAMP=0, MODE_LFSR=1, MODE_CONST=2, MODE_SILENCE=3.
  - LFSR seed and tap constants.
  - default WIDTH and SLOT values, also used by the receiver.
- One sub-module, i2s_pattern_gen: contains the ramp, LFSR and constant generators plus the mode mux. It has an advance strobe input and left_word/right_word outputs.
- The framing FSM and the serialiser stay in the top module.

Test Plan (WIDTH=24, SLOT=32):
- Reset, then enable=1: ws=0 for 32 cycles then 1 for 32 cycles. frame_strobe pulses every 64 cycles, first pulse on the first edge after enable.
- mode=0: the first frame's left slot carries 0x000000 on k=1..24 and the right slot 0xFFFFFF. The second frame carries 0x000001 and 0xFFFFFE. sd=0 at k=0 and k=25..31.
- mode=2: left serialises 0xAAAAAA MSB first and right serialises 0x555555. Connect to the receiver and check that its captured left/right words match.
- mode=1: first frame left=0x000001 and right=0x800000; the next frame carries the next LFSR state.
- enable dropped at left k=10: the frame completes all 64 cycles, then IDLE with ws=0 and sd=0. reset pulsed mid right slot: all outputs 0 on the next edge.
- TX_PARITY_EN defined, mode=0 with ramp=0x000003: par_left=0 (^0x000003), par_right=0 (^0xFFFFFC), both updated at the frame end.
